fpu_floor: RTL and testbench
============================

// Module: fpu_floor
// PURPOSE
//   IEEE-754 binary32 floor: y = largest integral float <= x (round toward -inf),
//   result returned as binary32, not as an integer.
//   Registered single-cycle FPU stage used by the float-to-int / floor instruction path.
//   Fully pipelined: accepts one operand per cycle, with no backpressure.
// PARAMETERS
//   none (format fixed: 1 sign, 8 exponent (bias 127), 23 mantissa bits)
// PORTS
//   clk       in   1   clock; all state updates on rising edge
//   rst       in   1   synchronous, active-high reset
//   in_valid  in   1   x is a valid operand this cycle
//   x         in   32  binary32 operand {s, e[7:0], m[22:0]}
//   out_valid out  1   y holds a valid result
//   y         out  32  binary32 floor(x)
// BEHAVIOUR
//   Interface: one clock (clk), synchronous active-high reset (rst).
//   Reset: out_valid=0, y=32'h0000_0000. Reset has priority over in_valid in the same edge.
//   Latency: exactly 1 cycle. Edge N samples in_valid/x; out_valid/y update at edge N.
//     out_valid(N) = in_valid(N-1). y holds its value while in_valid=0 (bubbles don't clear y).
//   Reset mid-stream: the result of the operand sampled in the reset cycle is discarded.
//   Compute (combinational from x, then registered), with s=x[31], e=x[30:23], m=x[22:0]:
//   - e==255 (Inf/NaN): y=x unchanged (NaN payload preserved).
//   - e>=150: x is already integral -> y=x.
//   - e==0 && m==0 (+/-0): y=x (sign of zero kept).
//   - e<127, nonzero (|x|<1, including denormals):
//       s=0 -> y=32'h0000_0000 (+0.0); s=1 -> y=32'hBF80_0000 (-1.0).
//   - 127<=e<=149: k=150-e fraction bits (1..23); mask=(1<<k)-1;
//       frac = m & mask. mi = m & ~mask.
//       s=0 or frac==0 -> y={s,e,mi} (truncate).
//       s=1 and frac!=0 -> magnitude += 2^k in the 24-bit significant {1,mi}:
//         sig={1'b1,mi}+(24'd1<<k); on carry out of bit 23:
//         e+1, mantissa=0. e+1<=150 always, so there is no overflow to Inf.
//         y={1'b1, e', sig[22:0]}.
//   No exception flags; no rounding-mode input.
//   No X propagation: y depends only on registered data.
// TESTING
//   2.5 (40200000) -> 40000000 (2.0); -2.5 (C0200000) -> C0400000 (-3.0), 1 cycle later.
//   -1.5 (BFC00000) -> C0000000 (-2.0, exponent carry); 0.75 (3F400000) -> 00000000.
//   Sweep x={1,j[7:0],23'h0} for j=0..255: j=0 -> 80000000; j=1..126 -> BF800000;
//     j=127..254 -> y==x; j=255 (-Inf) -> FF800000.
//   Edge cases: -1e-45 denormal (80000001) -> BF800000; 7FC00001 -> 7FC00001.
//     -8388607.5 (CAFFFFFF) -> CB000000.
//   Back-to-back valid stream, then in_valid gaps: out_valid is in_valid delayed 1; y holds in gaps.
//   Assert rst while streaming -> next edge out_valid=0, y=0; first post-reset result 1 cycle later.
//   Random 1e6 operands vs software floorf; compare bit-exact, excluding NaN.

Source files
------------

// File: rtl/fpu_floor.sv
// fpu_floor: registered IEEE-754 binary32 floor (round toward -inf), result
// returned as binary32. Accepts one operand per cycle, 1-cycle latency, no
// backpressure.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset (priority over in_valid)
//   in_valid   x carries a valid operand this cycle
//   x[31:0]    binary32 operand {s, e[7:0], m[22:0]}
//   out_valid  y holds a valid result (in_valid delayed one cycle)
//   y[31:0]    floor(x); holds its value across bubbles
module fpu_floor (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] x,
  output logic        out_valid,
  output logic [31:0] y
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] y_q, y_d;

  logic        s;
  logic [7:0]  e;
  logic [22:0] m;
  logic [7:0]  k;
  logic [22:0] mask;
  logic [22:0] frac;
  logic [22:0] mi;
  logic [23:0] sum_m;
  logic [7:0]  e_inc;
  logic [31:0] res;

  assign s = x[31];
  assign e = x[30:23];
  assign m = x[22:0];

  // Number of fractional mantissa bits; only meaningful for 127 <= e <= 149.
  assign k     = 8'd150 - e;
  assign mask  = 23'((24'd1 << k) - 24'd1);
  assign frac  = m & mask;
  assign mi    = m & ~mask;
  // Adding 2^k to the truncated mantissa: a carry out of bit 22 here is the
  // same as a carry out of bit 23 of the full significand {1, mi}. Because mi
  // is a multiple of 2^k, the mantissa is exactly zero when that happens.
  assign sum_m = {1'b0, mi} + (24'd1 << k);
  assign e_inc = e + 8'd1;

  always_comb begin
    res = x;
    if (e == 8'hFF || e >= 8'd150 || (e == 8'd0 && m == 23'd0)) begin
      res = x;
    end else if (e < 8'd127) begin
      res = s ? 32'hBF80_0000 : 32'h0000_0000;
    end else if (!s || frac == 23'd0) begin
      res = {s, e, mi};
    end else if (sum_m[23]) begin
      res = {1'b1, e_inc, 23'd0};
    end else begin
      res = {1'b1, e, sum_m[22:0]};
    end
  end

  always_comb begin
    out_valid_d = in_valid;
    y_d         = in_valid ? res : y_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= 32'h0000_0000;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_fpu_floor.sv
module tb_fpu_floor;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] x;
  logic        out_valid;
  logic [31:0] y;

  fpu_floor dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .out_valid (out_valid),
    .y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_y = 32'h0;
  logic        mon_iv;
  logic        mon_rst;
  logic [31:0] exp_y;

  // Reference: integer part via shift, bump for negative non-integers, then
  // renormalise the integer back into a float.
  function automatic logic [31:0] ref_floor(input logic [31:0] a);
    logic        sa;
    int          ea;
    int          kk;
    int          p;
    logic [31:0] sig;
    logic [31:0] n;
    logic [31:0] v;
    logic [31:0] t;
    logic        fnz;
    sa = a[31];
    ea = int'(a[30:23]);
    if (ea == 255 || ea >= 150 || a[30:0] == 31'd0) return a;
    if (ea < 127) begin
      n   = 32'd0;
      fnz = 1'b1;
    end else begin
      kk  = 150 - ea;
      sig = {8'd0, 1'b1, a[22:0]};
      n   = sig >> kk;
      fnz = ((sig << (32 - kk)) != 32'd0);
    end
    v = n + ((sa && fnz) ? 32'd1 : 32'd0);
    if (v == 32'd0) return 32'h0000_0000;
    p = 31;
    while (p > 0 && !v[p]) p--;
    t = v << (23 - p);
    return {sa, 8'(127 + p), t[22:0]};
  endfunction

  // Monitor: one check per edge on out_valid, plus a data check on y.
  always @(posedge clk) begin
    mon_iv  = in_valid;
    mon_rst = rst;
    #1;
    checks++;
    if (out_valid !== (mon_iv && !mon_rst)) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, mon_iv && !mon_rst, $time);
    end
    if (mon_rst) begin
      checks++;
      if (y !== 32'h0) begin
        errors++;
        $display("FAIL reset_y: got %h expected 00000000 at %0t", y, $time);
      end
      exp_q.delete();
    end else if (mon_iv) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got %h expected none at %0t", y, $time);
      end else begin
        exp_y = exp_q.pop_front();
        if (y !== exp_y) begin
          errors++;
          $display("FAIL result: got %h expected %h at %0t", y, exp_y, $time);
        end
      end
    end else begin
      checks++;
      if (y !== last_y) begin
        errors++;
        $display("FAIL hold_y: got %h expected %h at %0t", y, last_y, $time);
      end
    end
    last_y = y;
  end

  task automatic send(input logic [31:0] xv, input logic [31:0] ev);
    @(negedge clk);
    in_valid = 1'b1;
    x        = xv;
    exp_q.push_back(ev);
  endtask

  task automatic gap();
    @(negedge clk);
    in_valid = 1'b0;
    x        = $urandom;
  endtask

  vec_t vecs[9];
  logic [31:0] xs;
  logic [31:0] es;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    x        = 32'h0;

    vecs[0] = '{32'h4020_0000, 32'h4000_0000};
    vecs[1] = '{32'hC020_0000, 32'hC040_0000};
    vecs[2] = '{32'hBFC0_0000, 32'hC000_0000};
    vecs[3] = '{32'h3F40_0000, 32'h0000_0000};
    vecs[4] = '{32'h8000_0001, 32'hBF80_0000};
    vecs[5] = '{32'h7FC0_0001, 32'h7FC0_0001};
    vecs[6] = '{32'hCAFF_FFFF, 32'hCB00_0000};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{32'h3F80_0001, 32'h3F80_0000};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed vectors, back-to-back then with a bubble after each.
    for (int i = 0; i < 9; i++) send(vecs[i].x, vecs[i].y);
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].x, vecs[i].y);
      gap();
    end

    // Negative power-of-two exponent sweep.
    for (int j = 0; j < 256; j++) begin
      xs = {1'b1, 8'(j), 23'h0};
      if (j == 0)       es = 32'h8000_0000;
      else if (j < 127) es = 32'hBF80_0000;
      else if (j == 255) es = 32'hFF80_0000;
      else              es = xs;
      send(xs, es);
    end

    // Reset mid-stream: operand sampled with rst high must be discarded.
    send(32'hC020_0000, 32'hC040_0000);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    x        = 32'hBFC0_0000;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    send(32'h4020_0000, 32'h4000_0000);
    gap();
    gap();

    // Random operands with random bubbles, checked against the reference.
    for (int i = 0; i < 3000; i++) begin
      xs = $urandom;
      if ((i % 4) == 1) xs[30:23] = 8'($urandom_range(120, 155));
      send(xs, ref_floor(xs));
      if ($urandom_range(0, 3) == 0) gap();
    end

    gap();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
